// File: rtl/scope_pkg.sv
// Shared types and constants for the capture scope: FSM states, trigger modes, timebase codes.
package scope_pkg;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned PRETRIG = 8;
  localparam int unsigned PtrW    = 5;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  typedef enum logic [1:0] {
    TrigImm    = 2'b00,
    TrigRise   = 2'b01,
    TrigFall   = 2'b10,
    TrigEither = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    Tb1  = 2'b00,
    Tb4  = 2'b01,
    Tb16 = 2'b10,
    Tb64 = 2'b11
  } timebase_e;

  // Terminal divider count: a tick is issued once the divider reaches N-1.
  function automatic logic [5:0] tick_limit(timebase_e sel);
    case (sel)
      Tb1:     return 6'd0;
      Tb4:     return 6'd3;
      Tb16:    return 6'd15;
      default: return 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/scope_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector producing a one-clock pulse.
module scope_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      last_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~last_q;

endmodule

// File: rtl/tt_um_gfcwfzkm_scope_bfh_mht1_3.sv
// 32-sample triggered capture scope with selectable timebase and trigger mode.
// Optional pre-trigger history (8 samples) enabled by defining SCOPE_PRETRIG_EN.
module tt_um_gfcwfzkm_scope_bfh_mht1_3
  import scope_pkg::*;
#(
  parameter logic [7:0] TRIG_LEVEL = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic arm_rise, rd_rise;

  scope_sync_edge u_sync_arm (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (uio_in[0]),
    .rise_o (arm_rise)
  );

  scope_sync_edge u_sync_rd (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (uio_in[1]),
    .rise_o (rd_rise)
  );

  logic [3:0] cfg_meta_q, cfg_sync_q;
  timebase_e  sel;
  trig_mode_e mode;
  assign sel  = timebase_e'(cfg_sync_q[1:0]);
  assign mode = trig_mode_e'(cfg_sync_q[3:2]);

  state_e          state_q, state_d;
  logic [5:0]      div_q, div_d;
  logic [7:0]      prev_q, prev_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, start_idx;
  logic            busy_q, busy_d, done_q, done_d;
  logic            tick, trig_hit, trig_ok, mem_we;
  logic [7:0]      mem_q [DEPTH];

`ifdef SCOPE_PRETRIG_EN
  logic [PtrW-1:0] start_q, start_d;
  logic [3:0]      fill_q, fill_d;
  assign start_idx = start_q;
  assign trig_ok   = trig_hit && (fill_q == 4'(PRETRIG));
`else
  assign start_idx = '0;
  assign trig_ok   = trig_hit;
`endif

  assign tick = (div_q >= tick_limit(sel));

  always_comb begin
    logic above_prev, above_cur;
    above_prev = (prev_q >= TRIG_LEVEL);
    above_cur  = (ui_in >= TRIG_LEVEL);
    trig_hit   = 1'b0;
    case (mode)
      TrigImm:    trig_hit = 1'b1;
      TrigRise:   trig_hit = !above_prev && above_cur;
      TrigFall:   trig_hit = above_prev && !above_cur;
      TrigEither: trig_hit = above_prev != above_cur;
      default:    trig_hit = 1'b0;
    endcase
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (arm_rise) begin
      state_d = StArmed;
    end else begin
      case (state_q)
        StArmed:   if (tick && trig_ok) state_d = StCapture;
        // Last write lands just before the read origin, closing the 32-entry ring.
        StCapture: if (tick && (wr_ptr_q == start_idx - 1'b1)) state_d = StDone;
        default:   ;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    mem_we   = 1'b0;
`ifdef SCOPE_PRETRIG_EN
    start_d  = start_q;
    fill_d   = fill_q;
`endif
    if (arm_rise) begin
      wr_ptr_d = '0;
`ifdef SCOPE_PRETRIG_EN
      start_d  = '0;
      fill_d   = '0;
`endif
    end else begin
      case (state_q)
        StArmed: begin
`ifdef SCOPE_PRETRIG_EN
          if (tick) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (trig_ok) start_d = wr_ptr_q - PtrW'(PRETRIG);
            else if (fill_q != 4'(PRETRIG)) fill_d = fill_q + 1'b1;
          end
`else
          if (tick && trig_ok) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
`endif
        end
        StCapture: begin
          if (tick) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    rd_ptr_d = arm_rise ? '0 : (rd_rise ? rd_ptr_q + 1'b1 : rd_ptr_q);
    div_d    = (arm_rise || tick) ? '0 : div_q + 1'b1;
    prev_d   = tick ? ui_in : prev_q;
  end

  // Registered status outputs follow the next state.
  always_comb begin
    busy_d = (state_d == StArmed) || (state_d == StCapture);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_meta_q <= '0;
      cfg_sync_q <= '0;
`ifdef SCOPE_PRETRIG_EN
      start_q    <= '0;
      fill_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_meta_q <= uio_in[5:2];
      cfg_sync_q <= cfg_meta_q;
`ifdef SCOPE_PRETRIG_EN
      start_q    <= start_d;
      fill_q     <= fill_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= ui_in;
    end
  end

  logic [PtrW-1:0] rd_idx;
  assign rd_idx  = start_idx + rd_ptr_q;
  assign uo_out  = mem_q[rd_idx];
  assign uio_out = {busy_q, done_q, 6'b0};
  assign uio_oe  = 8'hC0;

  logic unused_pins;
  assign unused_pins = ^{ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_gfcwfzkm_scope_bfh_mht1_3.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural scope model.
module tb_tt_um_gfcwfzkm_scope_bfh_mht1_3;

`ifdef SCOPE_PRETRIG_EN
  localparam bit Pre = 1'b1;
`else
  localparam bit Pre = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_gfcwfzkm_scope_bfh_mht1_3 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: 0 idle, 1 armed, 2 capturing, 3 done.
  logic [7:0] m_mem [32];
  logic [7:0] m_hist [3];
  logic [7:0] m_prev;
  int m_state, m_wr, m_rd, m_start, m_fill, m_cnt, m_div, m_n, m_mode;
  bit m_arm, m_rdev, m_tick, m_hit;

  function automatic bit trig_fn(int mode, int prev, int cur);
    bit a_p, a_c;
    a_p = prev >= 128;
    a_c = cur >= 128;
    case (mode)
      0: return 1'b1;
      1: return !a_p && a_c;
      2: return a_p && !a_c;
      default: return a_p != a_c;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
      for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
      m_prev = 8'h00;
      m_state = 0; m_wr = 0; m_rd = 0; m_start = 0; m_fill = 0; m_cnt = 0; m_div = 0;
    end else begin
      // Pins reach the edge logic two clocks late; an edge is seen one clock after that.
      m_arm  = m_hist[1][0] && !m_hist[2][0];
      m_rdev = m_hist[1][1] && !m_hist[2][1];
      m_n    = 1 << (2 * int'(m_hist[1][3:2]));
      m_mode = int'(m_hist[1][5:4]);
      m_tick = m_div >= m_n - 1;
      m_hit  = trig_fn(m_mode, m_prev, ui_in);
      if (m_arm) begin
        m_state = 1; m_wr = 0; m_rd = 0; m_fill = 0; m_start = 0; m_cnt = 0;
      end else begin
        if (m_rdev) m_rd = (m_rd + 1) % 32;
        if (m_tick && m_state == 1) begin
          if (Pre) begin
            if (m_fill >= 8 && m_hit) begin
              m_start = (m_wr + 24) % 32;
              m_cnt = 1;
              m_state = 2;
            end else begin
              m_fill++;
            end
            m_mem[m_wr] = ui_in;
            m_wr = (m_wr + 1) % 32;
          end else if (m_hit) begin
            m_mem[0] = ui_in; m_wr = 1; m_cnt = 1; m_state = 2;
          end
        end else if (m_tick && m_state == 2) begin
          m_mem[m_wr] = ui_in;
          m_wr = (m_wr + 1) % 32;
          m_cnt++;
          if (m_cnt == (Pre ? 24 : 32)) m_state = 3;
        end
      end
      m_div = (m_arm || m_tick) ? 0 : m_div + 1;
      if (m_tick) m_prev = ui_in;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = uio_in;
    end
  end

  bit ramp = 1'b0;
  int ramp_step = 1;

  task automatic chk(string tag);
    logic [7:0] e_uo, e_uio;
    e_uo  = m_mem[(m_start + m_rd) % 32];
    e_uio = {(m_state == 1 || m_state == 2), (m_state == 3), 6'b0};
    n_vec++;
    assert (uo_out === e_uo) else begin
      n_err++;
      $error("FAIL %s uo_out: got %h want %h", tag, uo_out, e_uo);
    end
    n_vec++;
    assert (uio_out === e_uio) else begin
      n_err++;
      $error("FAIL %s uio_out: got %h want %h", tag, uio_out, e_uio);
    end
    n_vec++;
    assert (uio_oe === 8'hC0) else begin
      n_err++;
      $error("FAIL %s uio_oe: got %h want c0", tag, uio_oe);
    end
  endtask

  task automatic step(string tag);
    @(negedge clk);
    chk(tag);
    if (ramp) ui_in = ui_in + 8'(ramp_step);
  endtask

  task automatic arm_pulse(string tag);
    uio_in[0] = 1'b1; step(tag); step(tag);
    uio_in[0] = 1'b0; step(tag); step(tag);
  endtask

  task automatic rd_pulse(string tag);
    uio_in[1] = 1'b1; step(tag); step(tag);
    uio_in[1] = 1'b0; step(tag); step(tag);
  endtask

  task automatic wait_done(string tag, int budget);
    int i = 0;
    while (uio_out[6] !== 1'b1 && i < budget) begin
      step(tag);
      i++;
    end
    n_vec++;
    assert (uio_out[7:6] === 2'b01) else begin
      n_err++;
      $error("FAIL %s done-wait: busy/done got %b want 01", tag, uio_out[7:6]);
    end
  endtask

  task automatic chk_diff(string tag, int diff);
    logic [7:0] w_prev, w_cur, d;
    w_prev = uo_out;
    for (int i = 1; i < 32; i++) begin
      rd_pulse(tag);
      w_cur = uo_out;
      d = w_cur - w_prev;
      n_vec++;
      assert (d === 8'(diff)) else begin
        n_err++;
        $error("FAIL %s word %0d step: got %0d want %0d", tag, i, d, diff);
      end
      w_prev = w_cur;
    end
  endtask

  initial begin
    ui_in = 8'($urandom);
    #12;
    n_vec++;
    assert (uo_out === 8'h00 && uio_out === 8'h00 && uio_oe === 8'hC0) else begin
      n_err++;
      $error("FAIL reset outputs: got %h/%h/%h want 00/00/c0", uo_out, uio_out, uio_oe);
    end
    step("reset");
    rst_n = 1'b1;
    repeat (3) step("idle");

    // Immediate trigger, every clock, ramp: 32 consecutive values.
    uio_in[5:2] = 4'b0000;
    ramp = 1'b1; ramp_step = 1; ui_in = 8'($urandom);
    repeat (4) step("ramp1");
    arm_pulse("ramp1");
    wait_done("ramp1", 200);
    ramp = 1'b0;
    chk_diff("ramp1", 1);

    // Rising trigger on a step through the threshold.
    uio_in[5:2] = 4'b0100;
    ui_in = 8'h10;
    repeat (4) step("rise");
    arm_pulse("rise");
    repeat (12) step("rise");
    ui_in = 8'h90;
    wait_done("rise", 200);
    repeat (Pre ? 8 : 0) rd_pulse("rise");
    n_vec++;
    assert (uo_out === 8'h90) else begin
      n_err++;
      $error("FAIL rise trigger word: got %h want 90", uo_out);
    end

    // Falling trigger never satisfied by a rising step.
    uio_in[5:2] = 4'b1000;
    ui_in = 8'h10;
    repeat (4) step("fall");
    arm_pulse("fall");
    ui_in = 8'h90;
    repeat (100) step("fall");
    n_vec++;
    assert (uio_out[7:6] === 2'b10) else begin
      n_err++;
      $error("FAIL fall hold: busy/done got %b want 10", uio_out[7:6]);
    end

    // Divide-by-4 timebase: neighbouring words four apart.
    uio_in[5:2] = 4'b0001;
    ramp = 1'b1; ramp_step = 1;
    repeat (4) step("tb4");
    arm_pulse("tb4");
    wait_done("tb4", 400);
    ramp = 1'b0;
    chk_diff("tb4", 4);

    // Re-arm mid-capture restarts and rewinds the read pointer.
    ramp = 1'b1;
    arm_pulse("rearm");
    repeat (40) step("rearm");
    repeat (3) rd_pulse("rearm");
    arm_pulse("rearm");
    n_vec++;
    assert (uio_out[7:6] === 2'b10) else begin
      n_err++;
      $error("FAIL rearm status: busy/done got %b want 10", uio_out[7:6]);
    end
    wait_done("rearm", 400);
    ramp = 1'b0;

    // Random traffic on every input.
    for (int i = 0; i < 2500; i++) begin
      ui_in = 8'($urandom);
      if ($urandom_range(0, 199) == 0) uio_in[5:2] = 4'($urandom);
      if ($urandom_range(0, 149) == 0) uio_in[0] = ~uio_in[0];
      if ($urandom_range(0, 5) == 0) uio_in[1] = ~uio_in[1];
      uio_in[7:6] = 2'($urandom);
      step("random");
    end

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    assert (uo_out === 8'h00 && uio_out === 8'h00 && uio_oe === 8'hC0) else begin
      n_err++;
      $error("FAIL async reset: got %h/%h/%h want 00/00/c0", uo_out, uio_out, uio_oe);
    end
    step("reset2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_gfcwfzkm_scope_bfh_mht1_3.md
TT_UM_GFCWFZKM_SCOPE_BFH_MHT1_3 -- requirements
Module: tt_um_gfcwfzkm_scope_bfh_mht1_3

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameter: TRIG_LEVEL, default 8'h80, trigger threshold.
REQ-003 clk  input  1  system clock; all flops rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  tile select; ignored, block always runs.
REQ-006 ui_in  input  8  unsigned ADC sample, sampled synchronously.
REQ-007 uio_in  input  8  [0] arm, [1] rd_next, [3:2] timebase sel, [5:4] trigger mode; [7:6] unused.
REQ-008 uo_out  output  8  buffer word at current read index.
REQ-009 uio_out  output  8  [7] busy, [6] done, [5:0] constant 0.
REQ-010 uio_oe  output  8  constant 8'hC0.

Function
REQ-011 uio_in[5:0] SHALL pass 2-flop synchronizers; arm and rd_next act on synchronized rising edges, effective 3 clocks after the pin edge.
REQ-012 Tick SHALL occur every N clocks, N = 1, 4, 16, 64 for sel 00..11; divider counter cleared on arm edge.
REQ-013 On every tick, prev SHALL load the current ui_in.
REQ-014 Trigger, evaluated on ticks only: mode 00 immediate; 01 rising (prev < TRIG_LEVEL and ui_in >= TRIG_LEVEL); 10 falling (prev >= TRIG_LEVEL and ui_in < TRIG_LEVEL); 11 either.
REQ-015 States IDLE, ARMED, CAPTURE, DONE; an arm edge in any state SHALL go to ARMED and clear wr_ptr, rd_ptr and done.
REQ-016 ARMED: on trigger tick, write ui_in to buf[0], set wr_ptr=1, go to CAPTURE.
REQ-017 CAPTURE: each tick writes buf[wr_ptr] and increments it; the tick writing index 31 SHALL go to DONE.
REQ-018 Buffer SHALL be 32 x 8 bits; write and read pointers are 5 bits.
REQ-019 busy=1 in ARMED or CAPTURE; done=1 in DONE only; both registered.
REQ-020 uo_out SHALL equal buf[(start + rd_ptr) mod 32]; start=0 unless REQ-025 applies.
REQ-021 rd_next edge SHALL increment rd_ptr in any state, wrapping 31 to 0.
REQ-022 Arm edge and rd_next edge in the same clock: arm wins, rd_ptr=0.
REQ-023 Timebase or mode change mid-capture SHALL take effect on the next tick; no restart.

Reset
REQ-024 While rst_n is low: state IDLE, all pointers, prev, divider, synchronizers and buffer = 0; uo_out=8'h00, uio_out=8'h00, uio_oe=8'hC0.

Configuration
REQ-025 With SCOPE_PRETRIG_EN defined, ARMED SHALL write samples circularly each tick. A trigger is accepted only after 8 such writes. At trigger index p, 23 more samples are captured, then DONE; start=(p-8) mod 32 gives 8 pre-trigger samples.
REQ-026 Without SCOPE_PRETRIG_EN, ARMED writes nothing and start=0 (REQ-016/017).

Structure
REQ-027 Package scope_pkg SHALL hold the state enum, DEPTH=32, PRETRIG=8, trigger-mode and timebase encodings.
REQ-028 One sub-module, scope_sync_edge (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated for arm and rd_next.

Verification
REQ-029 Assert rst_n=0 -> uo_out=0x00, uio_out=0x00, uio_oe=0xC0.
REQ-030 Mode 00, sel 00, ui_in ramp +1 per clock, arm pulse -> busy for 32 ticks, then done=1; 31 rd_next pulses read 32 consecutive values.
REQ-031 Mode 01, ui_in=0x10, arm, then ui_in=0x90 -> first word read 0x90, done after 32 ticks.
REQ-032 Mode 10, ui_in steps 0x10 to 0x90 only -> busy stays 1, done stays 0.
REQ-033 Mode 00, sel 01, ramp +1 per clock -> adjacent captured words differ by 4.
REQ-034 Arm pulse mid-CAPTURE -> done=0, busy=1, rd_ptr=0, capture restarts; with SCOPE_PRETRIG_EN, a rising step read back lands at index 8.
